// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard controller: write-data sources, forwarding
// selects, the shadow-slot record and the slot match helper.
package hazard_pkg;

    // Wide enough for any practical register index; narrower indices zero-extend.
    localparam int SLOT_RD_W = 8;

    typedef logic [SLOT_RD_W-1:0] slot_rd_t;

    typedef enum logic [1:0] {
        WD_ALU  = 2'b00,
        WD_DRAM = 2'b01,
        WD_PC4  = 2'b10,
        WD_IMM  = 2'b11
    } wd_sel_e;

    typedef enum logic [2:0] {
        FWD_NONE   = 3'b000,
        FWD_EX_RES = 3'b001,
        FWD_EX_IMM = 3'b010,
        FWD_MEM    = 3'b011,
        FWD_WB     = 3'b100
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic     valid;
        slot_rd_t rd;
        logic     we;
        wd_sel_e  wd_sel;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: '0, we: 1'b0, wd_sel: WD_ALU};

    // x0 never matches, so it is never forwarded and never stalls.
    function automatic logic slot_hit(input slot_t s, input slot_rd_t rs, input logic used);
        return s.valid && s.we && (s.rd == rs) && (rs != '0) && used;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_pick.sv
// Per-operand forwarding select: picks the youngest matching shadow slot and
// flags a hazard when the EX producer's data is not available yet.
module fwd_pick
    import hazard_pkg::*;
(
    input  slot_t    ex,
    input  slot_t    mem,
    input  slot_t    wb,
    input  slot_rd_t rs,
    input  logic     used,
    output fwd_sel_e sel,
    output logic     hazard
);

    always_comb begin
        sel    = FWD_NONE;
        hazard = 1'b0;
        if (slot_hit(ex, rs, used)) begin
            case (ex.wd_sel)
                WD_ALU:  sel = FWD_EX_RES;
                WD_IMM:  sel = FWD_EX_IMM;
                // Load data and PC+4 only exist one stage later.
                default: hazard = 1'b1;
            endcase
        end else if (slot_hit(mem, rs, used)) begin
            sel = FWD_MEM;
        end else if (slot_hit(wb, rs, used)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow EX/MEM/WB slots, forwarding, load-use
// stall and branch squash. Optional perf counters under HAZARD_PERF_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | normal issue; a data hazard here issues a one-cycle stall
// ST_STALL | bubble cycle; EX holds a bubble so no new hazard can arise
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 3
) (
    input  logic              clk_cpu,
    input  logic              rst_cpu_n,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              rd_we_id,
    input  logic [1:0]        wd_sel_id,
    input  logic              branch_taken_ex,
    output logic [SEL_W-1:0]  rD1_sel,
    output logic [SEL_W-1:0]  rD2_sel,
    output logic              pc_stop,
    output logic              if_id_stop,
    output logic              if_id_flush,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
    output logic              id_ex_flush
`else
    output logic              id_ex_flush
`endif
);

    slot_t     ex_q, mem_q, wb_q;
    slot_t     id_slot;
    hz_state_e state_q, state_d;
    fwd_sel_e  sel1, sel2;
    logic      haz1, haz2;
    logic      data_hazard;
    logic      stall_raw;
    logic      bubble_raw;

    assign id_slot = '{valid:  1'b1,
                       rd:     slot_rd_t'(rd_id),
                       we:     rd_we_id,
                       wd_sel: wd_sel_e'(wd_sel_id)};

    fwd_pick u_pick_rs1 (
        .ex     (ex_q),
        .mem    (mem_q),
        .wb     (wb_q),
        .rs     (slot_rd_t'(rs1_id)),
        .used   (rs1_used_id),
        .sel    (sel1),
        .hazard (haz1)
    );

    fwd_pick u_pick_rs2 (
        .ex     (ex_q),
        .mem    (mem_q),
        .wb     (wb_q),
        .rs     (slot_rd_t'(rs2_id)),
        .used   (rs2_used_id),
        .sel    (sel2),
        .hazard (haz2)
    );

    always_ff @(posedge clk_cpu) begin
        if (!rst_cpu_n) begin
            ex_q    <= SLOT_EMPTY;
            mem_q   <= SLOT_EMPTY;
            wb_q    <= SLOT_EMPTY;
            state_q <= ST_RUN;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= bubble_raw ? SLOT_EMPTY : id_slot;
            state_q <= state_d;
            if (state_q == ST_STALL) begin
                assert (!data_hazard);
            end
        end
    end

    // A taken branch overrides the stall so the PC can load the target.
    always_comb begin
        data_hazard = haz1 | haz2;
        stall_raw   = data_hazard & ~branch_taken_ex;
        bubble_raw  = data_hazard | branch_taken_ex;

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (stall_raw) state_d = ST_STALL;
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        if (branch_taken_ex) begin
            state_d = ST_RUN;
        end

        rD1_sel     = '0;
        rD2_sel     = '0;
        pc_stop     = 1'b0;
        if_id_stop  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst_cpu_n) begin
            rD1_sel     = SEL_W'(sel1);
            rD2_sel     = SEL_W'(sel2);
            pc_stop     = stall_raw;
            if_id_stop  = stall_raw;
            if_id_flush = branch_taken_ex;
            id_ex_flush = bubble_raw;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk_cpu) begin
        if (!rst_cpu_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stop) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (if_id_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against an instruction-history reference model.
module tb_hazard_ctrl;

    localparam int WD_ALU  = 0;
    localparam int WD_DRAM = 1;
    localparam int WD_PC4  = 2;
    localparam int WD_IMM  = 3;

    logic       clk_cpu = 1'b0;
    logic       rst_cpu_n = 1'b0;
    logic [4:0] rs1_id = '0, rs2_id = '0, rd_id = '0;
    logic       rs1_used_id = 1'b0, rs2_used_id = 1'b0, rd_we_id = 1'b0;
    logic [1:0] wd_sel_id = '0;
    logic       branch_taken_ex = 1'b0;
    logic [2:0] rD1_sel, rD2_sel;
    logic       pc_stop, if_id_stop, if_id_flush, id_ex_flush;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    hazard_ctrl #(.REG_AW(5), .SEL_W(3)) dut (
        .clk_cpu         (clk_cpu),
        .rst_cpu_n       (rst_cpu_n),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .rs1_used_id     (rs1_used_id),
        .rs2_used_id     (rs2_used_id),
        .rd_id           (rd_id),
        .rd_we_id        (rd_we_id),
        .wd_sel_id       (wd_sel_id),
        .branch_taken_ex (branch_taken_ex),
        .rD1_sel         (rD1_sel),
        .rD2_sel         (rD2_sel),
        .pc_stop         (pc_stop),
        .if_id_stop      (if_id_stop),
        .if_id_flush     (if_id_flush),
`ifdef HAZARD_PERF_EN
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
`endif
        .id_ex_flush     (id_ex_flush)
    );

    always #5 clk_cpu = ~clk_cpu;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the last three instructions that entered ID/EX, newest first.
    typedef struct {bit v; int rd; bit we; int wd;} rec_t;
    rec_t hist[3];
    int   m_stall = 0;
    int   m_flush = 0;

    logic [9:0] exp_v, obs_v;

    function automatic void pick(input int rs, input bit used, output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        for (int age = 0; age < 3; age++) begin
            if (hist[age].v && hist[age].we && hist[age].rd == rs && rs != 0 && used) begin
                if (age == 0) begin
                    if (hist[0].wd == WD_ALU)      sel = 1;
                    else if (hist[0].wd == WD_IMM) sel = 2;
                    else                           haz = 1'b1;
                end else begin
                    sel = age + 2;
                end
                return;
            end
        end
    endfunction

    // Expected {rD1_sel, rD2_sel, pc_stop, if_id_stop, if_id_flush, id_ex_flush}.
    function automatic logic [9:0] model_eval();
        int s1, s2;
        bit h1, h2, haz, br;
        logic [9:0] r;
        pick(int'(rs1_id), rs1_used_id, s1, h1);
        pick(int'(rs2_id), rs2_used_id, s2, h2);
        haz = h1 | h2;
        br  = branch_taken_ex;
        r   = {s1[2:0], s2[2:0], haz & !br, haz & !br, br, br | haz};
        if (!rst_cpu_n) r = '0;
        return r;
    endfunction

    task automatic advance();
        if (!rst_cpu_n) begin
            for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 0, 1'b0, 0};
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (exp_v[3]) m_stall++;
            if (exp_v[1]) m_flush++;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = '{!exp_v[0], int'(rd_id), rd_we_id, int'(wd_sel_id)};
        end
    endtask

    task automatic drive(input bit rst, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit we, input int wd, input bit br);
        @(negedge clk_cpu);
        rst_cpu_n       = rst;
        rs1_id          = 5'(rs1);
        rs1_used_id     = u1;
        rs2_id          = 5'(rs2);
        rs2_used_id     = u2;
        rd_id           = 5'(rd);
        rd_we_id        = we;
        wd_sel_id       = 2'(wd);
        branch_taken_ex = br;
        #1;
        exp_v = model_eval();
        obs_v = {rD1_sel, rD2_sel, pc_stop, if_id_stop, if_id_flush, id_ex_flush};
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, WD_ALU, 0);
            advance();
        end
    endtask

    task automatic test_reset();
        drive(0, 5, 1, 6, 1, 5, 1, WD_DRAM, 1);
        n_cmp++;
        if (obs_v !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b want=%b", obs_v, 10'b0);
        end
        advance();
        drive(1, 5, 1, 6, 1, 7, 1, WD_ALU, 0);
        n_cmp++;
        if (obs_v !== exp_v || obs_v !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_empty_slots got=%b want=%b", obs_v, exp_v);
        end
        advance();
    endtask

    task automatic test_ex_alu_forward();
        nop(3);
        drive(1, 1, 1, 0, 0, 5, 1, WD_ALU, 0);
        advance();
        drive(1, 5, 1, 1, 1, 6, 1, WD_ALU, 0);
        n_cmp++;
        if (rD1_sel !== 3'b001 || rD2_sel !== 3'b000 || pc_stop !== 1'b0 || obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL ex_alu_forward got=%b want=%b", obs_v, exp_v);
        end
        advance();
    endtask

    task automatic test_load_use();
        int wds[2] = '{WD_DRAM, WD_PC4};
        foreach (wds[k]) begin
            nop(3);
            drive(1, 0, 0, 0, 0, 7, 1, wds[k], 0);
            advance();
            drive(1, 2, 1, 7, 1, 8, 1, WD_ALU, 0);
            n_cmp++;
            if (obs_v !== 10'b000_000_1101 || obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL load_use_stall wd=%0d got=%b want=%b", wds[k], obs_v, 10'b000_000_1101);
            end
            advance();
            drive(1, 2, 1, 7, 1, 8, 1, WD_ALU, 0);
            n_cmp++;
            if (obs_v !== 10'b000_011_0000 || obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL load_use_resume wd=%0d got=%b want=%b", wds[k], obs_v, 10'b000_011_0000);
            end
            advance();
        end
    endtask

    task automatic test_priority();
        // EX, MEM and WB all hold x3: EX wins with the immediate path.
        nop(3);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 3, 1, WD_IMM, 0);
            advance();
        end
        drive(1, 3, 1, 0, 0, 4, 1, WD_ALU, 0);
        n_cmp++;
        if (rD1_sel !== 3'b010 || obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL prio_ex got=%b want=%b", obs_v, exp_v);
        end
        advance();
        // EX emptied by a branch squash: MEM forwards.
        nop(3);
        drive(1, 0, 0, 0, 0, 3, 1, WD_IMM, 0);
        advance();
        drive(1, 0, 0, 0, 0, 3, 1, WD_IMM, 0);
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, WD_ALU, 1);
        advance();
        drive(1, 3, 1, 0, 0, 4, 1, WD_ALU, 0);
        n_cmp++;
        if (rD1_sel !== 3'b011 || obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL prio_mem got=%b want=%b", obs_v, exp_v);
        end
        advance();
        nop(3);
        drive(1, 0, 0, 0, 0, 3, 1, WD_IMM, 0);
        advance();
        nop(2);
        drive(1, 0, 0, 3, 1, 4, 1, WD_ALU, 0);
        n_cmp++;
        if (rD2_sel !== 3'b100 || rD1_sel !== 3'b000 || obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL prio_wb got=%b want=%b", obs_v, exp_v);
        end
        advance();
    endtask

    task automatic test_branch_over_hazard();
        nop(3);
        drive(1, 0, 0, 0, 0, 9, 1, WD_DRAM, 0);
        advance();
        drive(1, 9, 1, 0, 0, 10, 1, WD_ALU, 1);
        n_cmp++;
        if (obs_v !== 10'b000_000_0011 || obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL branch_wins got=%b want=%b", obs_v, 10'b000_000_0011);
        end
        advance();
        drive(1, 9, 1, 0, 0, 10, 1, WD_ALU, 0);
        n_cmp++;
        if (obs_v !== 10'b011_000_0000 || obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL branch_after got=%b want=%b", obs_v, 10'b011_000_0000);
        end
        advance();
    endtask

    task automatic test_x0();
        nop(3);
        drive(1, 0, 0, 0, 0, 0, 1, WD_ALU, 0);
        advance();
        drive(1, 0, 0, 0, 0, 0, 1, WD_PC4, 0);
        advance();
        drive(1, 0, 0, 0, 0, 0, 1, WD_DRAM, 0);
        advance();
        drive(1, 0, 1, 0, 1, 1, 1, WD_ALU, 0);
        n_cmp++;
        if (obs_v !== 10'b0 || obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL x0_never got=%b want=%b", obs_v, 10'b0);
        end
        advance();
    endtask

    task automatic test_reset_mid_stall();
        nop(3);
        drive(1, 0, 0, 0, 0, 7, 1, WD_DRAM, 0);
        advance();
        drive(1, 7, 1, 0, 0, 8, 1, WD_ALU, 0);
        n_cmp++;
        if (pc_stop !== 1'b1 || obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL midstall_enter got=%b want=%b", obs_v, exp_v);
        end
        advance();
        drive(0, 7, 1, 0, 0, 8, 1, WD_ALU, 1);
        n_cmp++;
        if (obs_v !== 10'b0) begin
            n_bad++;
            $display("FAIL midstall_reset got=%b want=%b", obs_v, 10'b0);
        end
        advance();
        drive(1, 7, 1, 7, 1, 8, 1, WD_ALU, 0);
        n_cmp++;
        if (obs_v !== 10'b0 || obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL midstall_resume got=%b want=%b", obs_v, 10'b0);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 59) != 0),
                  $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                  $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0));
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, obs_v, exp_v);
            end
            advance();
        end
`ifdef HAZARD_PERF_EN
        @(negedge clk_cpu);
        n_cmp++;
        if (stall_cnt !== 32'(m_stall) || flush_cnt !== 32'(m_flush)) begin
            n_bad++;
            $display("FAIL random_counters got=%0d/%0d want=%0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush);
        end
        rst_cpu_n = 1'b1;
`endif
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        drive(0, 0, 0, 0, 0, 0, 0, WD_ALU, 0);
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 7, 1, WD_DRAM, 0);
            advance();
            drive(1, 7, 1, 0, 0, 8, 1, WD_ALU, 0);
            advance();
            drive(1, 7, 1, 0, 0, 8, 1, WD_ALU, 0);
            advance();
        end
        drive(1, 0, 0, 0, 0, 0, 0, WD_ALU, 1);
        advance();
        nop(1);
        drive(1, 0, 0, 0, 0, 0, 0, WD_ALU, 1);
        advance();
        @(negedge clk_cpu);
        n_cmp++;
        if (stall_cnt !== 32'd3 || flush_cnt !== 32'd2) begin
            n_bad++;
            $display("FAIL perf_counts got=%0d/%0d want=3/2", stall_cnt, flush_cnt);
        end
        rst_cpu_n = 1'b0;
        advance();
        @(negedge clk_cpu);
        n_cmp++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL perf_cleared got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
        end
        rst_cpu_n = 1'b1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 0, 1'b0, 0};
        test_reset();
        test_ex_alu_forward();
        test_load_use();
        test_priority();
        test_branch_over_hazard();
        test_x0();
        test_reset_mid_stall();
        test_random();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It sits beside the decode stage and drives the `rD1_sel`/`rD2_sel` forwarding selects, the stall controls and the flush controls that the PC, IF/ID and ID/EX registers consume. It keeps its own shadow pipeline of destination-register information for the EX, MEM and WB stages. From that shadow pipeline it decides, each cycle, whether to forward, stall or squash.

## Interface
Parameters:
- `REG_AW`, default 5: register index width.
- `SEL_W`, default 3: forwarding-select width.

Ports:
- `clk_cpu` input 1: CPU clock; all state updates on the rising edge.
- `rst_cpu_n` input 1: reset, synchronous, active-low.
- `rs1_id` input `REG_AW`: rs1 index of the instruction in ID.
- `rs2_id` input `REG_AW`: rs2 index of the instruction in ID.
- `rs1_used_id` input 1: the ID instruction reads rs1.
- `rs2_used_id` input 1: the ID instruction reads rs2.
- `rd_id` input `REG_AW`: destination of the instruction in ID.
- `rd_we_id` input 1: the ID instruction writes rd.
- `wd_sel_id` input 2: write-data source of the ID instruction. Encoding: 00 ALU, 01 DRAM, 10 PC+4, 11 IMM.
- `branch_taken_ex` input 1: redirect resolved in EX this cycle.
- `rD1_sel` output `SEL_W`: rs1 forwarding select.
- `rD2_sel` output `SEL_W`: rs2 forwarding select.
- `pc_stop` output 1: hold the PC.
- `if_id_stop` output 1: hold IF/ID.
- `if_id_flush` output 1: squash IF/ID.
- `id_ex_flush` output 1: insert a bubble into ID/EX.
- `stall_cnt` output 32: stall-cycle counter; present only with `HAZARD_PERF_EN`.
- `flush_cnt` output 32: flush-event counter; present only with `HAZARD_PERF_EN`.

## Operation
- Shadow slots `ex`, `mem`, `wb` each hold {valid, rd, we, wd_sel}.
- Slot update at each posedge:
  - `wb` <= `mem`.
  - `mem` <= `ex`.
  - `ex` <= ID info. If `id_ex_flush` is 1, `ex` is loaded invalid instead.
- A slot matches rsN when all of these hold: valid, we, rd == rsN, rd != 0, and rsN_used_id.
- Per-operand select, evaluated in priority order:
  - `ex` matches, wd_sel ALU → 001.
  - `ex` matches, wd_sel IMM → 010.
  - `ex` matches, wd_sel DRAM or PC+4 → hazard. The select is don't-care and is driven as 000.
  - `mem` matches → 011.
  - `wb` matches → 100.
  - otherwise → 000.
- x0 is never forwarded and never causes a stall.
- Data hazard: if either operand hits the `ex`-slot hazard case:
  - `pc_stop` = 1, `if_id_stop` = 1, `id_ex_flush` = 1.
  - One bubble is inserted.
  - On the next cycle the producer sits in `mem` and the operand forwards with select 011.
- Control hazard: `branch_taken_ex` = 1 gives `if_id_flush` = 1, `id_ex_flush` = 1 and `pc_stop` = 0.
- Simultaneous branch and data hazard: the branch wins.
  - The stall is suppressed (`pc_stop` = 0, `if_id_stop` = 0) so the PC loads the target.
  - Both flushes are asserted.
- State machine, states RUN and STALL:
  - RUN → STALL when a data hazard stall is issued.
  - STALL → RUN unconditionally after one cycle.
  - In STALL a new data hazard is impossible, because `ex` holds a bubble. The state is kept for assertion checking and for the counters.
  - `branch_taken_ex` in either state forces the next state to RUN.

## Timing
- All outputs are combinational from the registered slots plus the current ID and EX inputs, valid in the same cycle.
- ID/EX registers the forwarded operand at the next edge.
- Load-use or PC+4-use costs exactly 1 stall cycle.
- A taken branch costs 2 squashed slots (IF/ID and ID/EX).
- Reset: `rst_cpu_n` low at a posedge:
  - All slots are cleared invalid, the FSM goes to RUN and the counters are zeroed.
  - While `rst_cpu_n` is low, every output is forced to 0.
- Deasserting reset mid-stall resumes in RUN with empty slots, so no stall is issued.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cnt` increments on every cycle with `pc_stop` = 1.
  - `flush_cnt` increments on every cycle with `if_id_flush` = 1.
  - Both are 32-bit, wrap at 2^32 and are cleared by reset.
- `HAZARD_PERF_EN` undefined: the counter ports and logic are absent, and the remaining behaviour is identical.

## Structure
- Shared package `hazard_pkg`:
  - wd_sel encodings (`WD_ALU`, `WD_DRAM`, `WD_PC4`, `WD_IMM`).
  - Forward-select encodings (`FWD_NONE` 000, `FWD_EX_RES` 001, `FWD_EX_IMM` 010, `FWD_MEM` 011, `FWD_WB` 100).
  - The slot struct type.
- Sub-module `fwd_pick`, instantiated twice, once per operand:
  - Inputs: the three slots, rs and used.
  - Outputs: the select and a hazard flag.

## Test plan
- `addi x5` in EX; `add x6,x5,x1` in ID → `rD1_sel` = 001, `rD2_sel` = 000, no stall.
- `lw x7` in EX; `sub x8,x2,x7` in ID → `pc_stop` = `if_id_stop` = `id_ex_flush` = 1 for 1 cycle. Next cycle `rD2_sel` = 011 and stall = 0.
- `lui x3` in EX, x3 in `mem`, x3 in `wb`; ID reads x3 → `rD1_sel` = 010 (EX priority). With `ex` invalid → 011; with only `wb` → 100.
- `lw x9` in EX, ID reads x9, `branch_taken_ex` = 1 → `pc_stop` = 0, `if_id_flush` = `id_ex_flush` = 1, FSM stays RUN.
- ID reads x0, with `wb` holding rd = 0 and we = 1 → select 000, no stall.
- `HAZARD_PERF_EN`: 3 load-use stalls and 2 branches, then reset pulse → counters read 3/2, then 0/0.
